// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types, lane count and load-extension helper for the byte-lane data memory
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_t;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam int LANES = 4;

  // Shift the addressed bytes down to bit 0, then sign- or zero-extend by access size.
  function automatic logic [31:0] load_extend(input logic [31:0] data, input logic [1:0] off,
                                              input size_t size, input logic uns);
    logic [31:0] sh;
    sh = data >> {off, 3'b000};
    case (size)
      SZ_BYTE: load_extend = {{24{~uns & sh[7]}}, sh[7:0]};
      SZ_HALF: load_extend = {{16{~uns & sh[15]}}, sh[15:0]};
      default: load_extend = sh;
    endcase
  endfunction

endpackage

// File: rtl/dmem_byte_lane.sv
// rtl/dmem_byte_lane.sv - one DEPTH x 8 byte lane with write enable and synchronous read
module dmem_byte_lane #(
  parameter int DEPTH = 512
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [7:0]               wdata,
  output logic [7:0]               rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
    rdata <= mem[idx];
  end

endmodule

// File: rtl/dmem_lanes.sv
// rtl/dmem_lanes.sv - byte-lane load/store data memory; DMEM_CLEAR_EN adds a post-reset zero-fill sweep
module dmem_lanes
  import dmem_pkg::*;
#(
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  localparam int IDX_W = $clog2(DEPTH);

  size_t                 size;
  logic                  accept;
  logic                  err;
  logic [LANES-1:0]      lane_sel;
  logic                  clr_active;
  logic [IDX_W-1:0]      clr_idx;
  logic [IDX_W-1:0]      lane_idx;
  logic [LANES-1:0][7:0] lane_wdata;
  logic [LANES-1:0][7:0] lane_rdata;

  logic                  ld_ok;
  size_t                 size_q;
  logic [1:0]            off_q;
  logic                  uns_q;

  assign size   = size_t'(req_size);
  assign accept = req_valid && req_ready;

  always_comb begin
    err = 1'b0;
    case (size)
      SZ_HALF: err = req_addr[0];
      SZ_WORD: err = |req_addr[1:0];
      SZ_RSVD: err = 1'b1;
      default: err = 1'b0;
    endcase
    // Any address bit above the word index would otherwise alias onto a valid entry.
    if (|(req_addr >> (IDX_W + 2))) err = 1'b1;
  end

  always_comb begin
    lane_sel = '0;
    case (size)
      SZ_BYTE: lane_sel = 4'b0001 << req_addr[1:0];
      SZ_HALF: lane_sel = req_addr[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: lane_sel = 4'b1111;
      default: lane_sel = '0;
    endcase
  end

  assign lane_idx = clr_active ? clr_idx : req_addr[IDX_W+1:2];

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign lane_wdata[k] = clr_active       ? 8'h00 :
                           (size == SZ_WORD) ? req_wdata[8*k +: 8] :
                           (size == SZ_HALF) ? req_wdata[8*(k%2) +: 8] :
                                               req_wdata[7:0];

    dmem_byte_lane #(.DEPTH(DEPTH)) u_lane (
      .clk   (clk),
      .we    (clr_active | (accept & req_we & ~err & lane_sel[k])),
      .idx   (lane_idx),
      .wdata (lane_wdata[k]),
      .rdata (lane_rdata[k])
    );
  end

`ifdef DMEM_CLEAR_EN
  state_t           state, state_next;
  logic [IDX_W-1:0] clr_cnt, clr_cnt_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_next;
      clr_cnt <= clr_cnt_next;
    end
  end

  always_comb begin
    state_next   = state;
    clr_cnt_next = clr_cnt;
    clr_active   = 1'b0;
    req_ready    = 1'b0;
    case (state)
      ST_CLEAR: begin
        clr_active   = 1'b1;
        clr_cnt_next = clr_cnt + 1'b1;
        if (clr_cnt == IDX_W'(DEPTH - 1)) state_next = ST_RUN;
      end
      ST_RUN:  req_ready = 1'b1;
      default: state_next = ST_CLEAR;
    endcase
  end

  assign clr_idx = clr_cnt;
`else
  assign req_ready  = 1'b1;
  assign clr_active = 1'b0;
  assign clr_idx    = '0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      ld_ok      <= 1'b0;
      size_q     <= SZ_BYTE;
      off_q      <= 2'b00;
      uns_q      <= 1'b0;
    end else begin
      resp_valid <= accept;
      resp_err   <= accept & err;
      ld_ok      <= accept & ~req_we & ~err;
      if (accept) begin
        size_q <= size;
        off_q  <= req_addr[1:0];
        uns_q  <= req_unsigned;
      end
    end
  end

  // Lane read registers were loaded at the accept edge; only the extension mux follows them.
  assign resp_rdata = ld_ok ? load_extend(lane_rdata, off_q, size_q, uns_q) : 32'h0;

endmodule

// File: tb/tb_dmem_lanes.sv
// tb/tb_dmem_lanes.sv - directed self-checking bench for dmem_lanes (DMEM_CLEAR_EN selects sweep checks)
module tb_dmem_lanes;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int tests  = 0;
  int failed = 0;

  dmem_lanes #(.DEPTH(512), .ADDR_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err);
    @(negedge clk);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    chk({tag, "/ready"}, {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk({tag, "/valid"}, {31'b0, resp_valid}, 32'd1);
    chk({tag, "/err"},   {31'b0, resp_err},   {31'b0, exp_err});
    chk({tag, "/rdata"}, resp_rdata, exp_rdata);
  endtask

  task automatic count_clear(output int n);
    n = 0;
    while (!req_ready && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  int n;

  initial begin
    reset        = 1'b1;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst/valid", {31'b0, resp_valid}, 32'd0);
    chk("rst/rdata", resp_rdata, 32'd0);
    chk("rst/err",   {31'b0, resp_err}, 32'd0);
`ifdef DMEM_CLEAR_EN
    chk("rst/ready", {31'b0, req_ready}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("midclr/ready", {31'b0, req_ready}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    count_clear(n);
    chk("clear/cycles", n, 32'd512);
    do_req("clr_ld0",   1'b0, 2'b10, 1'b0, 32'h0,   32'h0, 32'h0, 1'b0);
    do_req("clr_ld7fc", 1'b0, 2'b10, 1'b0, 32'h7FC, 32'h0, 32'h0, 1'b0);
`else
    chk("rst/ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
`endif

    do_req("st_w10",    1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    do_req("ld_w10",    1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    do_req("st_b23",    1'b1, 2'b00, 1'b0, 32'h23, 32'h12345680, 32'h0, 1'b0);
    do_req("ld_bs23",   1'b0, 2'b00, 1'b0, 32'h23, 32'h0, 32'hFFFFFF80, 1'b0);
    do_req("ld_bu23",   1'b0, 2'b00, 1'b1, 32'h23, 32'h0, 32'h00000080, 1'b0);
    do_req("st_w20",    1'b1, 2'b10, 1'b0, 32'h20, 32'h80011234, 32'h0, 1'b0);
    do_req("ld_hs22",   1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 32'hFFFF8001, 1'b0);
    do_req("ld_hu22",   1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 32'h00008001, 1'b0);
    do_req("ld_hs20",   1'b0, 2'b01, 1'b0, 32'h20, 32'h0, 32'h00001234, 1'b0);
    do_req("ld_bs21",   1'b0, 2'b00, 1'b0, 32'h21, 32'h0, 32'h00000012, 1'b0);
    do_req("st_h21err", 1'b1, 2'b01, 1'b0, 32'h21, 32'h0000ABCD, 32'h0, 1'b1);
    do_req("ld_w20a",   1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h80011234, 1'b0);
    do_req("st_h22",    1'b1, 2'b01, 1'b0, 32'h22, 32'hFFFFBEEF, 32'h0, 1'b0);
    do_req("ld_w20b",   1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'hBEEF1234, 1'b0);
    do_req("ld_bu22",   1'b0, 2'b00, 1'b1, 32'h22, 32'h0, 32'h000000EF, 1'b0);
    do_req("ld_w800",   1'b0, 2'b10, 1'b0, 32'h800, 32'h0, 32'h0, 1'b1);
    do_req("st_w810",   1'b1, 2'b10, 1'b0, 32'h810, 32'hCAFEF00D, 32'h0, 1'b1);
    do_req("ld_w10b",   1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    do_req("st_w7fc",   1'b1, 2'b10, 1'b0, 32'h7FC, 32'h11223344, 32'h0, 1'b0);
    do_req("ld_w7fc",   1'b0, 2'b10, 1'b0, 32'h7FC, 32'h0, 32'h11223344, 1'b0);
    do_req("rsvd_0",    1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
    do_req("ld_w12err", 1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 32'h0, 1'b1);
    do_req("ld_bu13",   1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'h000000DE, 1'b0);

    @(posedge clk);
    #1;
    chk("idle/valid", {31'b0, resp_valid}, 32'd0);
    chk("idle/rdata", resp_rdata, 32'd0);

    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_size  = 2'b10;
    req_addr  = 32'h10;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    reset     = 1'b1;
    #1;
    chk("kill/valid", {31'b0, resp_valid}, 32'd0);
    chk("kill/rdata", resp_rdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;
`ifdef DMEM_CLEAR_EN
    count_clear(n);
    chk("clear2/cycles", n, 32'd512);
    do_req("ld_w10c", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0);
`else
    do_req("ld_w10c", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/dmem_lanes.md
# dmem_lanes

Parametrised byte-lane data memory for the core's load/store stage. It accepts one load or store per cycle over a valid/ready request port and returns a registered response one cycle later. Loads support byte, half and word sizes with sign or zero extension. Misaligned, out-of-range or reserved-size accesses are flagged rather than silently aliased, and an optional post-reset sweep zero-fills the array.

## Interface
Parameters:
- DEPTH, 512, number of 32-bit words; power of two, ≥ 4.
- ADDR_W, 32, request byte-address width; must be ≥ log2(DEPTH)+2.

Ports:
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- resp_valid  out  1  one-cycle pulse per accepted request.
- resp_rdata  out  32  load result; 0 for stores and for errored accesses.
- resp_err  out  1  accepted request was misaligned, out of range or reserved size.

## Operation
- Storage is four byte lanes, lane k = byte k of each word, DEPTH entries each; word index = req_addr[log2(DEPTH)+1:2].
- Handshake: request accepted on a rising edge with req_valid && req_ready. No response backpressure. Back-to-back accepts are allowed every cycle.
- Error if any of:
  - req_size == 11;
  - half with addr[0] == 1;
  - word with addr[1:0] != 0;
  - req_addr[ADDR_W-1:log2(DEPTH)+2] != 0.
- Errored store writes nothing. Errored load returns rdata 0. Both pulse resp_err with resp_valid.
- Store:
  - byte writes lane addr[1:0] with wdata[7:0];
  - half writes lanes {addr[1],1} and {addr[1],0} with wdata[15:8] and wdata[7:0];
  - word writes all lanes.
- Load: selected lanes are shifted to bit 0. Byte is extended from bit 7 and half from bit 15, sign or zero per req_unsigned.
- FSM states: CLEAR, RUN.
  - Reset enters CLEAR (macro on) or RUN (macro off).
  - CLEAR: a counter walks 0..DEPTH-1, writing 0 to all lanes each cycle; req_ready = 0. Once entry DEPTH-1 is written, the next state is RUN.
  - RUN: req_ready = 1. Stays in RUN until reset.
- Reset asserted mid-CLEAR restarts the sweep at 0. Reset mid-RUN kills any pending response; array contents are retained.

## Timing
- Reset values: resp_valid 0, resp_rdata 0, resp_err 0, clear counter 0. req_ready is 0 (macro on) or 1 (macro off).
- Latency: response registered exactly 1 cycle after the accept edge.
- Load following a store to the same word in the next cycle returns the new data: the write commits at the store's accept edge, before the load's array read.
- Store and load in the same cycle cannot occur (single port).
- Clear sweep takes exactly DEPTH cycles after reset deassertion. req_ready rises on cycle DEPTH.

## Configuration
- DMEM_CLEAR_EN defined:
  - CLEAR state and counter are compiled in;
  - the array reads 0 everywhere after the sweep.
- DMEM_CLEAR_EN undefined:
  - no CLEAR state; RUN is entered directly from reset;
  - req_ready = 1 from the first cycle after reset;
  - array contents are unspecified until written.

## Structure
- dmem_pkg holds:
  - size typedef (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD);
  - state enum (ST_CLEAR, ST_RUN);
  - lane count constant (4).
- Sub-module dmem_byte_lane: DEPTH×8 array with write enable, write index and synchronous read. Instantiated four times. Alignment, extension and error logic stay in the top.

## Test plan
- Store word 0xDEADBEEF at 0x10, next cycle load word 0x10 → resp_rdata 0xDEADBEEF, resp_err 0, resp_valid 1 cycle after each accept.
- Store byte 0x80 at 0x23; load byte signed at 0x23 → 0xFFFFFF80; load byte unsigned → 0x00000080.
- Load half signed at 0x22 after the word 0x8001xxxx is stored at 0x20 → 0xFFFF8001. Store half at 0x21 → resp_err 1, word at 0x20 unchanged.
- DEPTH = 512: load word at 0x800 → resp_err 1, rdata 0. Size 11 at 0x0 → resp_err 1.
- DMEM_CLEAR_EN on: req_ready low for exactly 512 cycles after reset, then any word load → 0.
- Reset asserted at clear count 100 → counter returns to 0 and req_ready stays low for a full 512 cycles after deassert.
